// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: mode and FSM state encodings shared by the pulse generator
package pulse_gen_pkg;
  typedef enum logic [1:0] {MODE_OFF, MODE_CONT, MODE_BURST, MODE_SINGLE} mode_t;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/pulse_gen_chan.sv
// pulse_gen_chan: per-channel phase window compare, mask and output register
module pulse_gen_chan #(
  parameter int CNT_W = 14,
  parameter int VW    = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             mask,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] off,
  input  logic [CNT_W:0]   len,
  input  logic [VW-1:0]    weff,
  output logic             pulse
);
  logic [CNT_W:0] pos;
  // off is already reduced modulo len, so one conditional add handles the wrap
  always_comb pos = (cnt >= off) ? {1'b0, cnt - off} : {1'b0, cnt} + len - {1'b0, off};
  always_ff @(posedge clk) pulse <= !reset && run && mask && (VW'(pos) < weff);
endmodule

// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: multi-channel test-pulse generator (continuous, burst, single-shot)
// Define PULSE_GEN_STAGGER_EN to add stagger_cfg and per-channel phase offsets.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH     = 16,
  parameter int CNT_W      = 14,
  parameter int WID_W      = 8,
  parameter int BURST_W    = 8,
  parameter int DEF_PERIOD = 11999,
  parameter int DEF_WIDTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   period_cfg,
  input  logic [WID_W-1:0]   width_cfg,
  input  logic [BURST_W-1:0] burst_cfg,
  input  logic               trig_in,
  input  logic [NUM_CH-1:0]  chan_mask,
`ifdef PULSE_GEN_STAGGER_EN
  input  logic [CNT_W-1:0]   stagger_cfg,
`endif
  output logic [NUM_CH-1:0]  pulse_out,
  output logic               spare_out,
  output logic               busy,
  output logic               burst_done
);
  localparam int VW = (CNT_W > WID_W ? CNT_W : WID_W) + 1;
  state_t st;
  mode_t md;
  logic [CNT_W-1:0] cnt, per_a, per_p, per_n, per_e;
  logic [WID_W-1:0] wid_a, wid_p, wid_n;
  logic [BURST_W-1:0] bur_p, bur_n, rem;
  logic [CNT_W:0] len;
  logic [VW-1:0] weff;
  logic trig_q, run, wrap, apply, go, stop;
  always_comb begin
    per_n = cfg_valid ? period_cfg : per_p;
    wid_n = cfg_valid ? width_cfg : wid_p;
    bur_n = cfg_valid ? burst_cfg : bur_p;
    per_e = (per_a == '0) ? CNT_W'(1) : per_a;
    len   = {1'b0, per_e} + (CNT_W+1)'(1);
    weff  = (VW'(wid_a) < VW'(per_e)) ? VW'(wid_a) : VW'(per_e);
    run   = st == ST_RUN;
    wrap  = run && cnt == per_e;
    apply = !run || wrap;
    go    = !run && enable && (mode == MODE_CONT ||
            ((mode == MODE_BURST || mode == MODE_SINGLE) && trig_in && !trig_q));
    stop  = !enable || mode == MODE_OFF || mode != md;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= ST_IDLE;
      md         <= MODE_OFF;
      cnt        <= '0;
      rem        <= '0;
      trig_q     <= 1'b0;
      per_a      <= CNT_W'(DEF_PERIOD);
      per_p      <= CNT_W'(DEF_PERIOD);
      wid_a      <= WID_W'(DEF_WIDTH);
      wid_p      <= WID_W'(DEF_WIDTH);
      bur_p      <= BURST_W'(1);
      spare_out  <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      trig_q     <= trig_in;
      per_p      <= per_n;
      wid_p      <= wid_n;
      bur_p      <= bur_n;
      spare_out  <= run && VW'(cnt) < weff;
      burst_done <= 1'b0;
      if (apply) begin
        per_a <= per_n;
        wid_a <= wid_n;
      end
      if (!run) begin
        cnt <= '0;
        if (go) begin
          st  <= ST_RUN;
          md  <= mode_t'(mode);
          rem <= (mode == MODE_SINGLE || bur_n == '0) ? BURST_W'(1) : bur_n;
        end
      end else if (stop) begin
        st  <= ST_IDLE;
        cnt <= '0;
      end else begin
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
        if (wrap && md != MODE_CONT) begin
          rem <= rem - BURST_W'(1);
          if (rem == BURST_W'(1)) begin
            st         <= ST_IDLE;
            burst_done <= 1'b1;
          end
        end
      end
    end
  end
  assign busy = run;
`ifdef PULSE_GEN_STAGGER_EN
  logic [CNT_W-1:0] stg_p, stg_n;
  logic [CNT_W:0] len_n;
  always_comb begin
    stg_n = cfg_valid ? stagger_cfg : stg_p;
    len_n = (per_n == '0) ? (CNT_W+1)'(2) : {1'b0, per_n} + (CNT_W+1)'(1);
  end
  always_ff @(posedge clk) stg_p <= reset ? '0 : stg_n;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] off;
`ifdef PULSE_GEN_STAGGER_EN
    always_ff @(posedge clk)
      off <= reset ? '0 : apply ? CNT_W'(({5'd0, stg_n} * (CNT_W+5)'(i)) % {4'd0, len_n}) : off;
`else
    assign off = '0;
`endif
    pulse_gen_chan #(.CNT_W(CNT_W), .VW(VW)) u_chan (
      .clk(clk), .reset(reset), .run(run), .mask(chan_mask[i]), .cnt(cnt),
      .off(off), .len(len), .weff(weff), .pulse(pulse_out[i])
    );
  end
endmodule

// File: tb/tb_pulse_gen_multi.sv
// tb_pulse_gen_multi: directed table and sequence checks for pulse_gen_multi
module tb_pulse_gen_multi;
  import pulse_gen_pkg::*;
  logic clk = 1'b0;
  logic reset, enable, cfg_valid, trig_in, spare_out, busy, burst_done;
  logic [1:0] mode;
  logic [13:0] period_cfg;
  logic [7:0] width_cfg, burst_cfg;
  logic [15:0] chan_mask, pulse_out;
`ifdef PULSE_GEN_STAGGER_EN
  logic [13:0] stagger_cfg;
`endif
  int checks = 0, errors = 0, full_cnt = 0, part_cnt = 0;
  typedef struct {
    int en, md, cv, per, wid, bur, trg, pls, spr, bsy, dn;
  } vec_t;
  vec_t tbl[23];

  always #5 clk = ~clk;

  pulse_gen_multi dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .cfg_valid(cfg_valid),
    .period_cfg(period_cfg), .width_cfg(width_cfg), .burst_cfg(burst_cfg),
    .trig_in(trig_in), .chan_mask(chan_mask),
`ifdef PULSE_GEN_STAGGER_EN
    .stagger_cfg(stagger_cfg),
`endif
    .pulse_out(pulse_out), .spare_out(spare_out), .busy(busy), .burst_done(burst_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; mode = MODE_OFF; cfg_valid = 1'b0; trig_in = 1'b0;
    period_cfg = '0; width_cfg = '0; burst_cfg = '0; chan_mask = '0;
`ifdef PULSE_GEN_STAGGER_EN
    stagger_cfg = '0;
`endif
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input int per, input int wid, input int bur);
    period_cfg = per[13:0]; width_cfg = wid[7:0]; burst_cfg = bur[7:0];
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // advance until spare_out rises; n = cycles taken, hi = high samples seen
  task automatic wait_rise(input int lim, output int n, output int hi);
    logic p;
    n = 0;
    hi = 0;
    forever begin
      p = spare_out;
      tick();
      n++;
      if (spare_out) hi++;
      if (pulse_out == 16'hFFFF) full_cnt++;
      else if (pulse_out != 16'h0) part_cnt++;
      if ((spare_out && !p) || n >= lim) break;
    end
  endtask

  initial begin
    int n, hi, busy_cnt, rises, done_cnt, done_at, cnt_a, cnt_b, cnt_c;
    logic p;
    tbl[0]  = '{0, MODE_OFF,    1, 3, 2, 1, 0, 'h00, 0, 0, 0};
    tbl[1]  = '{1, MODE_CONT,   0, 0, 0, 0, 0, 'h00, 0, 1, 0};
    tbl[2]  = '{1, MODE_CONT,   0, 0, 0, 0, 0, 'hF0, 1, 1, 0};
    tbl[3]  = '{1, MODE_CONT,   0, 0, 0, 0, 0, 'hF0, 1, 1, 0};
    tbl[4]  = '{1, MODE_CONT,   0, 0, 0, 0, 0, 'h00, 0, 1, 0};
    tbl[5]  = '{1, MODE_CONT,   0, 0, 0, 0, 0, 'h00, 0, 1, 0};
    tbl[6]  = '{1, MODE_CONT,   0, 0, 0, 0, 0, 'hF0, 1, 1, 0};
    tbl[7]  = '{0, MODE_CONT,   0, 0, 0, 0, 0, 'hF0, 1, 0, 0};
    tbl[8]  = '{0, MODE_CONT,   0, 0, 0, 0, 0, 'h00, 0, 0, 0};
    tbl[9]  = '{1, MODE_BURST,  1, 2, 1, 2, 0, 'h00, 0, 0, 0};
    tbl[10] = '{1, MODE_BURST,  0, 0, 0, 0, 1, 'h00, 0, 1, 0};
    tbl[11] = '{1, MODE_BURST,  0, 0, 0, 0, 1, 'hF0, 1, 1, 0};
    tbl[12] = '{1, MODE_BURST,  0, 0, 0, 0, 0, 'h00, 0, 1, 0};
    tbl[13] = '{1, MODE_BURST,  0, 0, 0, 0, 1, 'h00, 0, 1, 0};
    tbl[14] = '{1, MODE_BURST,  0, 0, 0, 0, 0, 'hF0, 1, 1, 0};
    tbl[15] = '{1, MODE_BURST,  0, 0, 0, 0, 0, 'h00, 0, 1, 0};
    tbl[16] = '{1, MODE_BURST,  0, 0, 0, 0, 0, 'h00, 0, 0, 1};
    tbl[17] = '{1, MODE_BURST,  0, 0, 0, 0, 0, 'h00, 0, 0, 0};
    tbl[18] = '{1, MODE_SINGLE, 0, 0, 0, 0, 1, 'h00, 0, 1, 0};
    tbl[19] = '{1, MODE_SINGLE, 0, 0, 0, 0, 1, 'hF0, 1, 1, 0};
    tbl[20] = '{1, MODE_SINGLE, 0, 0, 0, 0, 0, 'h00, 0, 1, 0};
    tbl[21] = '{1, MODE_SINGLE, 0, 0, 0, 0, 0, 'h00, 0, 0, 1};
    tbl[22] = '{1, MODE_SINGLE, 0, 0, 0, 0, 0, 'h00, 0, 0, 0};

    reset = 1'b1; enable = 1'b1; mode = MODE_CONT; cfg_valid = 1'b0; trig_in = 1'b0;
    period_cfg = '0; width_cfg = '0; burst_cfg = '0; chan_mask = '1;
`ifdef PULSE_GEN_STAGGER_EN
    stagger_cfg = '0;
`endif
    tick();
    tick();
    chk("reset pulse", integer'(pulse_out), 0);
    chk("reset spare", integer'(spare_out), 0);
    chk("reset busy", integer'(busy), 0);
    chk("reset done", integer'(burst_done), 0);

    do_reset();
    chan_mask = 16'h00F0;
    for (int r = 0; r < 23; r++) begin
      enable = tbl[r].en[0]; mode = tbl[r].md[1:0]; cfg_valid = tbl[r].cv[0];
      period_cfg = tbl[r].per[13:0]; width_cfg = tbl[r].wid[7:0];
      burst_cfg = tbl[r].bur[7:0]; trig_in = tbl[r].trg[0];
      tick();
      chk($sformatf("row%0d pulse", r), integer'(pulse_out), tbl[r].pls);
      chk($sformatf("row%0d spare", r), integer'(spare_out), tbl[r].spr);
      chk($sformatf("row%0d busy", r), integer'(busy), tbl[r].bsy);
      chk($sformatf("row%0d done", r), integer'(burst_done), tbl[r].dn);
    end
    cfg_valid = 1'b0;
    trig_in = 1'b0;

    // default configuration: 4 high every 12000, all channels identical
    do_reset();
    chan_mask = 16'hFFFF; mode = MODE_CONT; enable = 1'b1;
    wait_rise(10, n, hi);
    chk("def first rise", n, 2);
    full_cnt = 0;
    part_cnt = 0;
    wait_rise(13000, n, hi);
    chk("def period", n, 12000);
    chk("def width", hi, 4);
    chk("def all ch high", full_cnt, 4);
    chk("def partial ch", part_cnt, 0);

    // mid-period reconfiguration lands only at the wrap
    repeat (99) tick();
    cfg(9, 3, 1);
    wait_rise(13000, n, hi);
    chk("recfg old period", n + 100, 12000);
    chk("recfg old highs", hi, 1);
    wait_rise(20, n, hi);
    chk("recfg new period", n, 10);
    chk("recfg new width", hi, 3);

    // width larger than period is clamped to period, leaving one low cycle
    cfg(9, 20, 1);
    wait_rise(20, n, hi);
    chk("clamp lead", n, 9);
    wait_rise(20, n, hi);
    chk("clamp period", n, 10);
    chk("clamp width", hi, 9);

    // zero width: counter keeps running, no pulses
    cfg(9, 0, 1);
    repeat (12) tick();
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    repeat (30) begin
      tick();
      if (spare_out) cnt_a++;
      if (pulse_out != 16'h0) cnt_b++;
      if (!busy) cnt_c++;
    end
    chk("w0 spare highs", cnt_a, 0);
    chk("w0 pulse highs", cnt_b, 0);
    chk("w0 busy lows", cnt_c, 0);

    // reset in the middle of a pulse
    cfg(9, 5, 1);
    repeat (12) tick();
    wait_rise(20, n, hi);
    chk("rst rise found", integer'(n <= 10), 1);
    tick();
    chk("rst pre spare", integer'(spare_out), 1);
    reset = 1'b1;
    tick();
    chk("rst spare", integer'(spare_out), 0);
    chk("rst pulse", integer'(pulse_out), 0);
    chk("rst busy", integer'(busy), 0);
    enable = 1'b0;
    tick();
    reset = 1'b0;

    // channel mask and enable drop mid-pulse
    cfg(9, 5, 1);
    chan_mask = 16'h00F0; mode = MODE_CONT; enable = 1'b1;
    wait_rise(20, n, hi);
    chk("mask rise", n, 2);
    chk("mask pulse", integer'(pulse_out), 'h00F0);
    chk("mask spare", integer'(spare_out), 1);
    tick();
    enable = 1'b0;
    tick();
    chk("drop busy", integer'(busy), 0);
    chk("drop spare lag", integer'(spare_out), 1);
    tick();
    chk("drop spare", integer'(spare_out), 0);
    chk("drop pulse", integer'(pulse_out), 0);

    // burst of 3, period 10, with an ignored trigger mid-burst
    cfg(9, 3, 3);
    chan_mask = 16'hFFFF; mode = MODE_BURST; enable = 1'b1;
    tick();
    chk("burst no trig", integer'(busy), 0);
    busy_cnt = 0; rises = 0; done_cnt = 0; done_at = 0;
    trig_in = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 2 || c == 16) trig_in = 1'b0;
      if (c == 15) trig_in = 1'b1;
      p = spare_out;
      tick();
      if (busy) busy_cnt++;
      if (spare_out && !p) rises++;
      if (burst_done) begin
        done_cnt++;
        done_at = c;
      end
    end
    chk("burst busy cycles", busy_cnt, 30);
    chk("burst pulses", rises, 3);
    chk("burst done count", done_cnt, 1);
    chk("burst done time", done_at, 31);

`ifdef PULSE_GEN_STAGGER_EN
    begin
      int first[16];
      do_reset();
      stagger_cfg = 14'd3;
      cfg(31, 2, 1);
      chan_mask = 16'hFFFF; mode = MODE_CONT; enable = 1'b1;
      wait_rise(10, n, hi);
      chk("stg rise", n, 2);
      for (int k = 0; k < 16; k++) first[k] = -1;
      for (int t = 0; t < 40; t++) begin
        for (int k = 0; k < 16; k++)
          if (pulse_out[k] && first[k] < 0) first[k] = t;
        tick();
      end
      for (int k = 0; k < 16; k++)
        chk($sformatf("stg ch%0d", k), first[k], (3 * k) % 32);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
